// File: rtl/bip_debug_unit.sv
// Host-command controller for the BIP CPU: gates execution through a clock enable,
// stops on HLT or the cycle limit, and reports PC/ACC/cycle count as six bytes.
module bip_debug_unit #(
  parameter logic [4:0]  HLT_OPCODE = 5'b00000,
  parameter logic [15:0] MAX_CYCLES = 16'hFFFF,
  parameter logic [7:0]  CMD_RST    = 8'h52,
  parameter logic [7:0]  CMD_RUN    = 8'h53,
  parameter logic [7:0]  CMD_STEP   = 8'h50
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_done,
  input  logic [10:0] pc_in,
  input  logic [15:0] acc_in,
  input  logic [15:0] instr_in,
  output logic        cpu_en,
  output logic        cpu_reset,
  output logic        halted
);

  typedef enum logic [2:0] {IDLE, CLR, RUN, STEP, SEND, WAIT_TX} state_t;

  state_t      state, next;
  logic [15:0] counter, snap_pc, snap_acc, snap_cnt;
  logic [2:0]  idx;
  logic        hlt, lim;
  logic [47:0] rep;
  logic [7:0]  tx_byte;

  assign hlt = (instr_in[15:11] == HLT_OPCODE);
  assign lim = (counter == MAX_CYCLES);

  always_comb begin
    next   = state;
    cpu_en = 1'b0;
    case (state)
      IDLE: if (rx_done) begin
        if (rx_data == CMD_RST)       next = CLR;
        else if (rx_data == CMD_RUN)  next = RUN;
        else if (rx_data == CMD_STEP) next = STEP;
      end
      CLR:  next = IDLE;
      RUN: begin
        cpu_en = !hlt && !lim;
        if (hlt || lim) next = SEND;
      end
      STEP: begin
        cpu_en = !hlt;
        next   = SEND;
      end
      SEND:    next = WAIT_TX;
      WAIT_TX: if (tx_done) next = (idx == 3'd5) ? IDLE : SEND;
      default: next = IDLE;
    endcase
  end

  // The first byte is sent in the same cycle the snapshot is taken, so it comes from the live inputs.
  assign rep = (idx == 3'd0) ? {5'b0, pc_in, acc_in, counter} : {snap_pc, snap_acc, snap_cnt};

  always_comb begin
    case (idx)
      3'd0:    tx_byte = rep[47:40];
      3'd1:    tx_byte = rep[39:32];
      3'd2:    tx_byte = rep[31:24];
      3'd3:    tx_byte = rep[23:16];
      3'd4:    tx_byte = rep[15:8];
      default: tx_byte = rep[7:0];
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      counter   <= 16'd0;
      snap_pc   <= 16'd0;
      snap_acc  <= 16'd0;
      snap_cnt  <= 16'd0;
      idx       <= 3'd0;
      tx_data   <= 8'd0;
      tx_start  <= 1'b0;
      cpu_reset <= 1'b0;
      halted    <= 1'b0;
    end else begin
      state     <= next;
      tx_start  <= 1'b0;
      cpu_reset <= (next == CLR);
      case (state)
        CLR: begin
          counter <= 16'd0;
          halted  <= 1'b0;
        end
        RUN: begin
          if (cpu_en) counter <= counter + 16'd1;
          if (hlt)    halted  <= 1'b1;
        end
        STEP: begin
          if (cpu_en && counter != 16'hFFFF) counter <= counter + 16'd1;
          halted <= hlt;
        end
        SEND: begin
          if (idx == 3'd0) begin
            snap_pc  <= {5'b0, pc_in};
            snap_acc <= acc_in;
            snap_cnt <= counter;
          end
          tx_data  <= tx_byte;
          tx_start <= 1'b1;
        end
        WAIT_TX: if (tx_done) idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bip_debug_unit.sv
// Directed + randomized bench for bip_debug_unit with a toy CPU and a reference
// model that replays each command as a tiny instruction-set simulation.
module tb_bip_debug_unit;

  localparam int MAXC = 10;

  logic        clk = 1'b0, reset = 1'b1;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_done = 1'b0, tx_done = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_start, cpu_en, cpu_reset, halted;
  logic [10:0] cpu_pc;
  logic [15:0] cpu_acc, instr;

  logic [15:0] mem [0:2047];
  logic [15:0] tab [0:2047];
  logic        ld = 1'b0;
  logic [10:0] ld_val = 11'd0;

  int checks = 0, errors = 0;
  int en_cnt = 0, rstp_cnt = 0, done_cnt = 0;
  bit chk_stable = 1'b1;
  logic [7:0] byt [$];
  int m_cnt = 0;
  bit m_halt = 1'b0;

  bip_debug_unit #(.MAX_CYCLES(16'(MAXC))) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done(rx_done),
    .tx_data(tx_data), .tx_start(tx_start), .tx_done(tx_done),
    .pc_in(cpu_pc), .acc_in(cpu_acc), .instr_in(instr),
    .cpu_en(cpu_en), .cpu_reset(cpu_reset), .halted(halted));

  always #5 clk = ~clk;

  // Toy CPU: ACC loads a per-address constant, opcode 5'h1F jumps, everything else falls through.
  assign instr = mem[cpu_pc];
  always @(posedge clk) begin
    if (cpu_reset) begin
      cpu_pc  <= 11'd0;
      cpu_acc <= 16'd0;
    end else if (ld) cpu_pc <= ld_val;
    else if (cpu_en) begin
      cpu_acc <= tab[cpu_pc];
      cpu_pc  <= (mem[cpu_pc][15:11] == 5'h1F) ? mem[cpu_pc][10:0] : cpu_pc + 11'd1;
    end
  end

  always @(negedge clk) begin
    if (cpu_en)    en_cnt++;
    if (cpu_reset) rstp_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // UART tx stand-in: records each byte, answers tx_done after a random delay.
  initial forever begin
    @(negedge clk);
    if (tx_start === 1'b1) begin
      byt.push_back(tx_data);
      repeat ($urandom_range(1, 4)) @(negedge clk);
      if (chk_stable) chk("tx_hold", 32'(tx_data), 32'(byt[$]));
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
      done_cnt++;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic load_pc(input logic [10:0] v);
    @(negedge clk);
    ld_val = v;
    ld = 1'b1;
    @(negedge clk);
    ld = 1'b0;
  endtask

  task automatic do_reset_cmd();
    int r0;
    r0 = rstp_cnt;
    send_byte(8'h52);
    repeat (2) @(negedge clk);
    chk("cpu_reset_pulse", 32'(rstp_cnt - r0), 32'd1);
    chk("halted_after_R", 32'(halted), 32'd0);
    m_cnt = 0;
    m_halt = 1'b0;
  endtask

  // Reference: replay the command on a copy of the CPU state using the rules directly.
  task automatic model_cmd(input logic [7:0] c, output int ncyc, output logic [47:0] erep);
    logic [10:0] p;
    logic [15:0] a;
    p = cpu_pc;
    a = cpu_acc;
    ncyc = 0;
    if (c == 8'h53) begin
      while (1) begin
        if (mem[p][15:11] == 5'd0) begin m_halt = 1'b1; break; end
        if (m_cnt == MAXC) break;
        a = tab[p];
        p = (mem[p][15:11] == 5'h1F) ? mem[p][10:0] : p + 11'd1;
        m_cnt++;
        ncyc++;
      end
    end else begin
      if (mem[p][15:11] == 5'd0) m_halt = 1'b1;
      else begin
        a = tab[p];
        p = (mem[p][15:11] == 5'h1F) ? mem[p][10:0] : p + 11'd1;
        ncyc = 1;
        m_halt = 1'b0;
        if (m_cnt < 65535) m_cnt++;
      end
    end
    erep = {5'b0, p, a, 16'(m_cnt)};
  endtask

  task automatic wait_report(input string tag);
    int i;
    for (i = 0; i < 3000 && done_cnt < 6; i++) @(negedge clk);
    if (done_cnt < 6) chk({tag, "_timeout"}, 32'(done_cnt), 32'd6);
    repeat (3) @(negedge clk);
  endtask

  // Run/step command with full report check; inject drops an 'S' into WAIT_TX.
  task automatic do_cmd(input string tag, input logic [7:0] c, input bit inject);
    int e0, ncyc, i;
    logic [47:0] erep;
    byt.delete();
    done_cnt = 0;
    e0 = en_cnt;
    model_cmd(c, ncyc, erep);
    send_byte(c);
    if (inject) begin
      for (i = 0; i < 500 && byt.size() == 0; i++) @(negedge clk);
      send_byte(8'h53);
    end
    wait_report(tag);
    if (inject) repeat (20) @(negedge clk);
    chk({tag, "_nbytes"}, 32'(byt.size()), 32'd6);
    for (int k = 0; k < 6 && k < byt.size(); k++)
      chk($sformatf("%s_byte%0d", tag, k), 32'(byt[k]), 32'(erep[47-8*k -: 8]));
    chk({tag, "_en_cycles"}, 32'(en_cnt - e0), 32'(ncyc));
    chk({tag, "_halted"}, 32'(halted), 32'(m_halt));
  endtask

  initial begin
    int n, e0, r0, i;
    for (int k = 0; k < 2048; k++) begin mem[k] = 16'h0800; tab[k] = 16'h0000; end
    repeat (3) @(negedge clk);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_cpu_en", 32'(cpu_en), 32'd0);
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    reset = 1'b0;

    // Three instructions then HLT at PC 3, ACC ends at 0xAABB.
    for (int k = 0; k < 3; k++) mem[k] = 16'h0800 | 16'(k);
    tab[2] = 16'hAABB;
    mem[3] = 16'h0000;
    do_reset_cmd();
    do_cmd("run_hlt", 8'h53, 1'b0);
    chk("run_hlt_acc_lit", {byt.size() > 3 ? byt[2] : 8'h0, byt.size() > 3 ? byt[3] : 8'h0}, 32'hAABB);

    // Step from PC 5, then step onto a HLT.
    mem[5] = 16'h0801; tab[5] = 16'h0012; mem[6] = 16'h0000;
    do_reset_cmd();
    load_pc(11'd5);
    do_cmd("step", 8'h50, 1'b0);
    do_cmd("step_hlt", 8'h50, 1'b0);

    // Endless loop stopped by the cycle limit.
    mem[0] = 16'h0800; tab[0] = 16'h1111;
    mem[1] = 16'hF800; tab[1] = 16'h2222;
    do_reset_cmd();
    do_cmd("run_lim", 8'h53, 1'b0);

    // Unknown byte in IDLE, and a run command during WAIT_TX, are both ignored.
    byt.delete();
    e0 = en_cnt;
    r0 = rstp_cnt;
    send_byte(8'h41);
    repeat (10) @(negedge clk);
    chk("ign_A_bytes", 32'(byt.size()), 32'd0);
    chk("ign_A_en", 32'(en_cnt - e0), 32'd0);
    chk("ign_A_rst", 32'(rstp_cnt - r0), 32'd0);
    do_cmd("ign_S", 8'h50, 1'b1);

    // Random programs: some single steps, then a run to HLT.
    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) begin
        mem[k] = {5'($urandom_range(1, 30)), 11'($urandom)};
        tab[k] = 16'($urandom);
      end
      mem[n] = {5'd0, 11'($urandom)};
      do_reset_cmd();
      for (int s = $urandom_range(0, n); s > 0; s--)
        do_cmd($sformatf("rnd%0d_step", it), 8'h50, 1'b0);
      do_cmd($sformatf("rnd%0d_run", it), 8'h53, 1'b0);
    end

    // Reset during the third report byte aborts everything.
    do_reset_cmd();
    byt.delete();
    done_cnt = 0;
    send_byte(8'h53);
    for (i = 0; i < 3000 && byt.size() < 3; i++) @(negedge clk);
    if (byt.size() < 3) chk("abort_timeout", 32'(byt.size()), 32'd3);
    chk_stable = 1'b0;
    reset = 1'b1;
    #1;
    chk("abort_tx_start", 32'(tx_start), 32'd0);
    chk("abort_cpu_en", 32'(cpu_en), 32'd0);
    chk("abort_halted", 32'(halted), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    m_cnt = 0;
    m_halt = 1'b0;
    repeat (12) @(negedge clk);
    chk_stable = 1'b1;
    do_cmd("post_abort_step", 8'h50, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
